// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory read
// at a time and hands each returned word to the IR. Downstream stalls park
// the word in a holding register. Redirects that arrive mid-read wait in
// FLUSH until the in-flight read completes.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ir_load,
  output logic [31:0] ir_data,
  output logic [31:0] ir_pc
);

  typedef enum logic [1:0] {REQ, HOLD, FLUSH} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic [31:0] hold_word;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // PC, pending target, held word and fetch state sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      state     <= REQ;
      hold_word <= '0;
      tgt       <= '0;
    end else begin
      unique case (state)
        REQ: begin
          if (imem_resp) begin
            if (redirect) begin
              pc <= redirect_tgt;
            end else if (!stall) begin
              pc <= pc + 32'd4;
            end else begin
              hold_word <= imem_rdata;
              state     <= HOLD;
            end
          end else if (redirect) begin
            // address must stay put until the in-flight read completes
            tgt   <= redirect_tgt;
            state <= FLUSH;
          end
        end
        HOLD: begin
          if (redirect) begin
            hold_word <= '0;
            pc        <= redirect_tgt;
            state     <= REQ;
          end else if (!stall) begin
            pc    <= pc + 32'd4;
            state <= REQ;
          end
        end
        FLUSH: begin
          if (redirect) begin
            tgt <= redirect_tgt;
          end
          if (imem_resp) begin
            // a redirect in the same cycle as the response is the latest target
            pc    <= redirect ? redirect_tgt : tgt;
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  // Memory request and IR handoff, decoded from state and live inputs
  always_comb begin
    imem_address = pc;
    imem_read    = 1'b0;
    ir_load      = 1'b0;
    ir_data      = '0;
    ir_pc        = pc;
    if (rst) begin
      ir_pc = RESET_PC;
    end else begin
      unique case (state)
        REQ: begin
          imem_read = 1'b1;
          ir_data   = imem_rdata;
          ir_load   = imem_resp && !redirect && !stall;
        end
        HOLD: begin
          ir_data = hold_word;
          ir_load = !redirect && !stall;
        end
        FLUSH: begin
          imem_read = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
